// File: rtl/asyncfifo_pkg.sv
// rtl/asyncfifo_pkg.sv - shared async FIFO constants and Gray/binary conversion helpers
package asyncfifo_pkg;

  localparam int DEF_PTR_WIDTH = 3;

  // Operands are zero-extended to 32 bits; leading zeros leave both conversions unaffected.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - width-parameterized two-flop synchronizer, async active-high reset to 0
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rptr_handler.sv
// rtl/rptr_handler.sv - async FIFO read-side pointer, empty/almost-empty, fill count and underflow
module rptr_handler
  import asyncfifo_pkg::*;
#(
  parameter int PTR_WIDTH     = DEF_PTR_WIDTH,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic               rclk,
  input  logic               rrst,
  input  logic               r_en,
  input  logic [PTR_WIDTH:0] g_wptr,
  input  logic               underflow_clr,
  output logic [PTR_WIDTH:0] b_rptr,
  output logic [PTR_WIDTH:0] g_rptr,
  output logic               empty,
  output logic               almost_empty,
  output logic [PTR_WIDTH:0] rd_count,
  output logic               underflow
);

  localparam int PW = PTR_WIDTH + 1;

  logic [PTR_WIDTH:0] r_b_rptr;
  logic [PTR_WIDTH:0] r_g_rptr;
  logic               r_empty;
  logic               r_almost_empty;
  logic [PTR_WIDTH:0] r_rd_count;
  logic               r_underflow;

  logic [PTR_WIDTH:0] w_wptr_sync;
  logic [PTR_WIDTH:0] w_wptr_bin;
  logic               w_accept;
  logic               w_underrun;
  logic [PTR_WIDTH:0] w_b_next;
  logic [PTR_WIDTH:0] w_g_next;
  logic [PTR_WIDTH:0] w_count_next;

  sync_2ff #(.WIDTH(PW)) u_wptr_sync (
    .clk (rclk),
    .rst (rrst),
    .i_d (g_wptr),
    .o_q (w_wptr_sync)
  );

  assign w_accept     = r_en & ~r_empty;
  assign w_underrun   = r_en & r_empty;
  assign w_b_next     = r_b_rptr + PW'(w_accept);
  assign w_g_next     = PW'(bin2gray(32'(w_b_next)));
  assign w_wptr_bin   = PW'(gray2bin(32'(w_wptr_sync)));
  // Modular subtraction; the wrap bit lets a full FIFO read as 2**PTR_WIDTH rather than 0.
  assign w_count_next = w_wptr_bin - w_b_next;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_b_rptr       <= '0;
      r_g_rptr       <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_count     <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_b_rptr       <= w_b_next;
      r_g_rptr       <= w_g_next;
      r_empty        <= (w_g_next == w_wptr_sync);
      r_almost_empty <= (32'(w_count_next) <= 32'(AEMPTY_THRESH));
      r_rd_count     <= w_count_next;
      if (w_underrun)
        r_underflow <= 1'b1;
      else if (underflow_clr)
        r_underflow <= 1'b0;
    end
  end

  assign b_rptr       = r_b_rptr;
  assign g_rptr       = r_g_rptr;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign rd_count     = r_rd_count;
  assign underflow    = r_underflow;

endmodule
